mem_bus_arbiter2: RTL and testbench
===================================

// Module: mem_bus_arbiter2
// PURPOSE
//  Two-master round-robin arbiter for the native memory bus (valid/ready/addr/wdata/wstrb/rdata).
//  Shares one memory port between master 0 (CPU core) and master 1 (program loader / DMA).
//  Latches the winning request, drives the shared slave and returns a registered one-cycle ready
//  with data. A bus timeout completes hung accesses with an error word.
// PARAMETERS
//  TIMEOUT    64            max cycles in BUSY waiting for s_ready; 0 disables the timeout
//  ERR_RDATA  32'hDEADBEEF  rdata returned to the master on a timeout
// PORTS
//  clk        in   1   clock, rising edge
//  resetn     in   1   asynchronous active-low reset
//  m0_valid   in   1   master 0 request; held until m0_ready
//  m0_instr   in   1   master 0 instruction-fetch flag
//  m0_addr    in   32  master 0 byte address
//  m0_wdata   in   32  master 0 write data
//  m0_wstrb   in   4   master 0 byte strobes; 0 = read
//  m0_ready   out  1   master 0 completion, one-cycle pulse
//  m0_rdata   out  32  master 0 read data, valid while m0_ready=1
//  m1_*       -    -   identical set for master 1
//  s_valid    out  1   slave request
//  s_instr    out  1   slave instr flag
//  s_addr     out  32  slave address
//  s_wdata    out  32  slave write data
//  s_wstrb    out  4   slave strobes
//  s_ready    in   1   slave completion
//  s_rdata    in   32  slave read data, sampled when s_ready=1
//  grant      out  1   master owning the current/last transaction
//  busy       out  1   1 in BUSY or RESP
//  bus_err    out  1   one-cycle pulse on a timeout completion
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE, last_grant=1 (m0 wins the first tie), timeout counter 0.
//   Reset mid-transaction: s_valid and mX_ready drop immediately; nothing is replayed.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: sample m0_valid/m1_valid. If neither -> stay. If one -> grant it. If both -> grant the
//   master != last_grant. On the grant edge: latch instr/addr/wdata/wstrb into s_*, set s_valid=1,
//   grant=winner, last_grant=winner, counter=0, go to BUSY.
//  BUSY: s_* are held constant from the latched registers; master input changes are ignored.
//   s_ready=1 -> RESP, s_valid=0, mX_ready=1 for the granted master, mX_rdata=s_rdata.
//   Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> RESP, s_valid=0, mX_ready=1,
//   mX_rdata=ERR_RDATA, bus_err=1. Else counter+1.
//   s_ready and timeout in the same cycle: s_ready wins and bus_err stays 0.
//  RESP: lasts exactly one cycle. mX_ready/bus_err are cleared on the next edge, then -> IDLE.
//   The master's valid during RESP is stale and is never sampled.
//  Latency: request visible in IDLE at cycle N gives s_valid at N+1. s_ready sampled at cycle K
//   gives mX_ready at K+1. Minimum 3 cycles per access; back-to-back tied requests alternate.
//  The non-granted master's ready is 0 throughout. Its rdata holds the last value.
//  s_ready outside BUSY is ignored. Writes and reads follow the same flow; rdata is passed even on writes.
//  A master dropping valid during BUSY does not abort the access. It still receives its ready pulse.
//  Counter width: clog2(TIMEOUT+1), minimum 1 bit. No wrap occurs because the count stops at TIMEOUT-1.
// TESTING
//  T1: m0 read 0x10, slave ready 2 cycles after s_valid, s_rdata=0x12345678 -> s_addr=0x10,
//      m0_ready one pulse with m0_rdata=0x12345678; m1_ready stays 0.
//  T2: m0 and m1 both valid in the first cycle after reset -> grant order 0,1,0,1 across four
//      accesses; every s_addr matches the owner's address.
//  T3: m1 write 0x40 data 0xA5A5A5A5 wstrb=4'b0011 while m0 is idle -> s_wstrb=0011,
//      s_wdata=A5A5A5A5, m1_ready one pulse; next IDLE sees no stale request.
//  T4: TIMEOUT=8, slave never ready -> m0_ready and bus_err rise together 9 cycles after the
//      request cycle; m0_rdata=DEADBEEF; s_valid=0 afterwards.
//  T5: s_ready asserted in the counter==TIMEOUT-1 cycle -> normal completion, bus_err=0.
//  T6: resetn pulled low while in BUSY -> s_valid, busy and grant are 0 within the same cycle;
//      after release, the first tie is granted to m0.

Source files
------------

// File: rtl/mem_bus_arbiter2.sv
// Two-master round-robin arbiter for the native memory bus, with a registered
// one-cycle completion and a bus timeout that answers hung accesses with an error word.
module mem_bus_arbiter2 #(
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        busy,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] count;
    logic          req_any;
    logic          winner;
    logic          timeout_hit;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        req_any = m0_valid | m1_valid;
        if (m0_valid && m1_valid) begin
            winner = ~last_grant;
        end else begin
            winner = m1_valid;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (count == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            count      <= '0;
            s_valid    <= 1'b0;
            s_instr    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
            m0_ready   <= 1'b0;
            m0_rdata   <= '0;
            m1_ready   <= 1'b0;
            m1_rdata   <= '0;
            grant      <= 1'b0;
            busy       <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        s_valid    <= 1'b1;
                        s_instr    <= winner ? m1_instr : m0_instr;
                        s_addr     <= winner ? m1_addr  : m0_addr;
                        s_wdata    <= winner ? m1_wdata : m0_wdata;
                        s_wstrb    <= winner ? m1_wstrb : m0_wstrb;
                        grant      <= winner;
                        last_grant <= winner;
                        count      <= '0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end

                // A real slave response takes priority over a timeout in the same cycle.
                BUSY: begin
                    if (s_ready) begin
                        s_valid <= 1'b0;
                        if (grant) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= s_rdata;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= s_rdata;
                        end
                        state <= RESP;
                    end else if (timeout_hit) begin
                        s_valid <= 1'b0;
                        bus_err <= 1'b1;
                        if (grant) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= ERR_RDATA;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= ERR_RDATA;
                        end
                        state <= RESP;
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                RESP: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    bus_err  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter2.sv
// Randomized bench for mem_bus_arbiter2: masters and a slave are driven at random,
// and a transaction-level model predicts every grant, slave request and completion.
module tb_mem_bus_arbiter2;

    localparam int          TIMEOUT = 8;
    localparam logic [31:0] ERR     = 32'hDEADBEEF;

    logic        clk;
    logic        resetn;
    logic        mv[2];
    logic        mi[2];
    logic [31:0] ma[2];
    logic [31:0] mw[2];
    logic [3:0]  ms[2];
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        grant, busy, bus_err;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cycles;
    } resp_t;

    resp_t resp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_done[2];
    int n_err   = 0;
    int n_edge  = 0;

    logic en_tie, en_rand;
    int   tie_req;
    logic pend[2];

    mem_bus_arbiter2 #(.TIMEOUT(TIMEOUT), .ERR_RDATA(ERR)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m0_valid (mv[0]),
        .m0_instr (mi[0]),
        .m0_addr  (ma[0]),
        .m0_wdata (mw[0]),
        .m0_wstrb (ms[0]),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (mv[1]),
        .m1_instr (mi[1]),
        .m1_addr  (ma[1]),
        .m1_wdata (mw[1]),
        .m1_wstrb (ms[1]),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_instr  (s_instr),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant    (grant),
        .busy     (busy),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Master driver: each master holds its request until its ready pulse.
    initial begin
        int  tie_seen;
        logic tie_go;
        logic rdy;
        tie_seen = 0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; mi[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0; pend[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                for (int i = 0; i < 2; i++) begin
                    mv[i]   = 1'b0;
                    pend[i] = 1'b0;
                end
            end else begin
                tie_go = (tie_req != tie_seen) && !pend[0] && !pend[1];
                if (tie_go) tie_seen = tie_req;
                for (int i = 0; i < 2; i++) begin
                    rdy = (i == 0) ? m0_ready : m1_ready;
                    if (pend[i] && rdy) begin
                        pend[i] = 1'b0;
                        mv[i]   = 1'b0;
                    end else if (pend[i] && mv[i] && s_valid && grant == i[0]
                                 && $urandom_range(0, 3) == 0) begin
                        mv[i] = 1'b0;
                        ma[i] = $urandom;
                    end
                    if (!pend[i] && (en_tie || tie_go || (en_rand && $urandom_range(0, 2) == 0))) begin
                        pend[i] = 1'b1;
                        mv[i]   = 1'b1;
                        mi[i]   = 1'($urandom_range(0, 1));
                        ma[i]   = $urandom;
                        mw[i]   = $urandom;
                        ms[i]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
                    end
                end
            end
        end
    end

    // Slave: picks a latency per request and records the response the master must see.
    initial begin
        int          c;
        int          lat;
        logic [31:0] rd;
        logic        active;
        active = 1'b0; c = 0; lat = 0; rd = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) resp_q.delete();
            if (!resetn || !s_valid) begin
                active  = 1'b0;
                s_ready = 1'($urandom_range(0, 1));
                s_rdata = $urandom;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    c      = 0;
                    lat    = $urandom_range(0, 10);
                    rd     = $urandom;
                    resp_q.push_back('{data:   (lat < TIMEOUT) ? rd : ERR,
                                       err:    (lat >= TIMEOUT),
                                       cycles: (lat < TIMEOUT) ? lat + 1 : TIMEOUT});
                end else begin
                    c++;
                end
                s_ready = (c == lat);
                s_rdata = (c == lat) ? rd : $urandom;
            end
        end
    end

    // Monitor: walks idle -> busy -> response at transaction level and compares each cycle.
    initial begin
        typedef enum {P_IDLE, P_BUSY, P_RESP} phase_t;
        phase_t      phase;
        logic        last;
        logic        owner;
        logic [31:0] last_rd[2];
        logic        e_instr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        resp_t       cur;
        int          bc;
        phase = P_IDLE; last = 1'b1; owner = 1'b0; bc = 0;
        last_rd[0] = '0; last_rd[1] = '0;
        e_instr = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        cur = '{data: '0, err: 1'b0, cycles: 1};
        n_done[0] = 0; n_done[1] = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                phase = P_IDLE;
                last  = 1'b1;
                last_rd[0] = '0;
                last_rd[1] = '0;
                checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_grant", 32'(grant), 32'd0);
                checkOutput("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
                checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
                checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
                checkOutput("rst_m1_rdata", m1_rdata, 32'd0);
                checkOutput("rst_s_addr", s_addr, 32'd0);
            end else begin
                case (phase)
                    P_IDLE: begin
                        checkOutput("idle_s_valid", 32'(s_valid), 32'd0);
                        checkOutput("idle_busy", 32'(busy), 32'd0);
                        checkOutput("idle_ready", 32'({m1_ready, m0_ready}), 32'd0);
                        checkOutput("idle_bus_err", 32'(bus_err), 32'd0);
                        checkOutput("idle_m0_rdata_hold", m0_rdata, last_rd[0]);
                        checkOutput("idle_m1_rdata_hold", m1_rdata, last_rd[1]);
                        if (mv[0] || mv[1]) begin
                            owner   = (mv[0] && mv[1]) ? ~last : mv[1];
                            last    = owner;
                            e_instr = mi[owner];
                            e_addr  = ma[owner];
                            e_wdata = mw[owner];
                            e_wstrb = ms[owner];
                            bc      = 0;
                            phase   = P_BUSY;
                        end
                    end
                    P_BUSY: begin
                        if (bc == 0) begin
                            checkOutput("slave_saw_request", 32'(resp_q.size() != 0), 32'd1);
                            if (resp_q.size() != 0) cur = resp_q.pop_front();
                            else cur = '{data: ERR, err: 1'b0, cycles: 1};
                        end
                        checkOutput("busy_s_valid", 32'(s_valid), 32'd1);
                        checkOutput("busy_busy", 32'(busy), 32'd1);
                        checkOutput("busy_grant", 32'(grant), 32'(owner));
                        checkOutput("busy_s_instr", 32'(s_instr), 32'(e_instr));
                        checkOutput("busy_s_addr", s_addr, e_addr);
                        checkOutput("busy_s_wdata", s_wdata, e_wdata);
                        checkOutput("busy_s_wstrb", 32'(s_wstrb), 32'(e_wstrb));
                        checkOutput("busy_ready", 32'({m1_ready, m0_ready}), 32'd0);
                        checkOutput("busy_bus_err", 32'(bus_err), 32'd0);
                        bc++;
                        if (bc >= cur.cycles) phase = P_RESP;
                    end
                    P_RESP: begin
                        checkOutput("resp_s_valid", 32'(s_valid), 32'd0);
                        checkOutput("resp_busy", 32'(busy), 32'd1);
                        checkOutput("resp_grant", 32'(grant), 32'(owner));
                        checkOutput("resp_ready", 32'({m1_ready, m0_ready}),
                                    owner ? 32'd2 : 32'd1);
                        checkOutput("resp_rdata", owner ? m1_rdata : m0_rdata, cur.data);
                        checkOutput("resp_other_rdata_hold", owner ? m0_rdata : m1_rdata,
                                    last_rd[~owner]);
                        checkOutput("resp_bus_err", 32'(bus_err), 32'(cur.err));
                        last_rd[owner] = cur.data;
                        n_done[owner]++;
                        if (cur.err) n_err++;
                        if (!cur.err && cur.cycles == TIMEOUT) n_edge++;
                        phase = P_IDLE;
                    end
                    default: phase = P_IDLE;
                endcase
            end
        end
    end

    task automatic applyStimulus(input int cycles, input logic tie, input logic rnd);
        en_tie  = tie;
        en_rand = rnd;
        repeat (cycles) @(posedge clk);
        en_tie  = 1'b0;
        en_rand = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn  = 1'b0;
        en_tie  = 1'b0;
        en_rand = 1'b0;
        tie_req = 0;
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;

        applyStimulus(60, 1'b1, 1'b0);
        applyStimulus(3000, 1'b0, 1'b1);

        for (int i = 0; i < 100; i++) begin
            if (!pend[0] && !pend[1] && !busy) break;
            @(posedge clk);
        end
        checkOutput("drain_idle", 32'({pend[0], pend[1], busy}), 32'd0);

        // Reset in the middle of a granted access.
        tie_req++;
        for (int i = 0; i < 10 && !s_valid; i++) @(negedge clk);
        checkOutput("t6_granted", 32'(s_valid), 32'd1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("t6_async_s_valid", 32'(s_valid), 32'd0);
        checkOutput("t6_async_busy", 32'(busy), 32'd0);
        checkOutput("t6_async_grant", 32'(grant), 32'd0);
        checkOutput("t6_async_ready", 32'({m1_ready, m0_ready}), 32'd0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        tie_req++;
        for (int i = 0; i < 10 && !s_valid; i++) @(negedge clk);
        checkOutput("t6_regrant", 32'(s_valid), 32'd1);
        checkOutput("t6_first_tie_grant", 32'(grant), 32'd0);
        repeat (40) @(posedge clk);

        checkOutput("m0_served", 32'(n_done[0] > 20), 32'd1);
        checkOutput("m1_served", 32'(n_done[1] > 20), 32'd1);
        checkOutput("timeouts_seen", 32'(n_err > 0), 32'd1);
        checkOutput("last_cycle_ready_seen", 32'(n_edge > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
